// File: rtl/operand_fetch.sv
// operand_fetch: decode, bypass and scoreboard hazard check feeding a registered operand bundle to execute
module operand_fetch #(
    parameter int DSIZE = 16,
    parameter int RSIZE = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    input  logic [15:0]      in_pc,
    output logic [RSIZE-1:0] RAddr1,
    output logic [RSIZE-1:0] RAddr2,
    input  logic [DSIZE-1:0] RData1,
    input  logic [DSIZE-1:0] RData2,
    input  logic             wb_en,
    input  logic [RSIZE-1:0] wb_addr,
    input  logic [DSIZE-1:0] wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_op,
    output logic [RSIZE-1:0] out_rd,
    output logic             out_wen,
    output logic [DSIZE-1:0] out_a,
    output logic [DSIZE-1:0] out_b,
    output logic [3:0]       out_imm,
    output logic [15:0]      out_pc,
    output logic [15:0]      stall_cnt
);
    localparam int NREG = 1 << RSIZE;

    logic             valid_q, valid_d, wen_q, wen_d;
    logic [NREG-1:0]  pend_q, pend_d;
    logic [15:0]      stall_q, stall_d, pc_q, pc_d;
    logic [3:0]       op_q, op_d, imm_q, imm_d;
    logic [RSIZE-1:0] rd_q, rd_d;
    logic [DSIZE-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       op;
    logic [RSIZE-1:0] rd, rs1, rs2, src1, src2;
    logic             is_alu, is_lw, is_sw, is_lh, writes, hazard, accept;

    function automatic logic bypass(input logic [RSIZE-1:0] r);
        return wb_en && wb_addr == r;
    endfunction

    function automatic logic busy(input logic [RSIZE-1:0] r);
        return pend_q[r] && !bypass(r);
    endfunction

    function automatic logic [DSIZE-1:0] opnd(input logic [RSIZE-1:0] r, input logic [DSIZE-1:0] rdata);
        return r == '0 ? '0 : bypass(r) ? wb_data : rdata;
    endfunction

    always_comb begin
        op       = in_instr[15:12];
        rd       = in_instr[11:8];
        rs1      = in_instr[7:4];
        rs2      = in_instr[3:0];
        is_alu   = !op[3];
        is_lw    = op == 4'h8;
        is_sw    = op == 4'h9;
        is_lh    = op[3:1] == 3'b101;
        src1     = is_lh ? rd : (is_alu || is_lw || is_sw) ? rs1 : '0;
        src2     = is_alu ? rs2 : is_sw ? rd : '0;
        writes   = (is_alu || is_lw || is_lh) && rd != '0;
        hazard   = busy(src1) || busy(src2) || (writes && busy(rd));
        in_ready = !hazard && (!valid_q || out_ready) && !flush;
        accept   = in_valid && in_ready;
        pend_d   = pend_q;
        if (wb_en)
            pend_d[wb_addr] = 1'b0;
        // a discarded bundle will never write back, so release its destination
        if (flush && valid_q && wen_q)
            pend_d[rd_q] = 1'b0;
        if (accept && writes)
            pend_d[rd] = 1'b1;
        pend_d[0] = 1'b0;
        valid_d  = accept || (valid_q && !out_ready && !flush);
        op_d     = accept ? op : op_q;
        rd_d     = accept ? rd : rd_q;
        wen_d    = accept ? writes : wen_q;
        imm_d    = accept ? in_instr[3:0] : imm_q;
        pc_d     = accept ? in_pc : pc_q;
        a_d      = accept ? opnd(src1, RData1) : a_q;
        b_d      = !accept ? b_q : is_lh ? {{(DSIZE-4){1'b0}}, in_instr[7:4]} : opnd(src2, RData2);
        stall_d  = (in_valid && hazard && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            valid_q <= 1'b0;
            pend_q  <= '0;
            stall_q <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            imm_q   <= '0;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            valid_q <= valid_d;
            pend_q  <= pend_d;
            stall_q <= stall_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            wen_q   <= wen_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign RAddr1    = src1;
    assign RAddr2    = src2;
    assign out_valid = valid_q;
    assign out_op    = op_q;
    assign out_rd    = rd_q;
    assign out_wen   = wen_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_imm   = imm_q;
    assign out_pc    = pc_q;
    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed vector table plus randomized traffic checked against a scoreboard model
module tb_operand_fetch;
    logic        Clock = 1'b0, Reset = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic        wb_en = 1'b0, in_ready, out_valid, out_wen;
    logic [15:0] in_instr = '0, in_pc = '0, wb_data = '0;
    logic [3:0]  wb_addr = '0, RAddr1, RAddr2, out_op, out_rd, out_imm;
    logic [15:0] RData1, RData2, out_a, out_b, out_pc, stall_cnt;
    logic [15:0] regs [16];

    assign RData1 = regs[RAddr1];
    assign RData2 = regs[RAddr2];

    always #5 Clock = ~Clock;

    operand_fetch dut (
        .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .RAddr1(RAddr1), .RAddr2(RAddr2),
        .RData1(RData1), .RData2(RData2), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd), .out_wen(out_wen), .out_a(out_a),
        .out_b(out_b), .out_imm(out_imm), .out_pc(out_pc), .stall_cnt(stall_cnt)
    );

    int n_chk = 0, n_fail = 0;
    bit pend [16];
    bit mv = 0, mwen = 0;
    logic [15:0] ma = '0, mb = '0, mpc = '0, mstall = '0;
    logic [3:0]  mop = '0, mrd = '0, mimm = '0;

    typedef struct {
        bit rst, iv; logic [15:0] ins; bit ordy, wbe; logic [3:0] wba; logic [15:0] wbd; bit fl;
        bit e_rdy, e_ov, e_chk; logic [15:0] e_a, e_b; logic [3:0] e_rd; bit e_wen; logic [15:0] e_st;
    } vec_t;
    vec_t tbl [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Sources and write intent straight from the op-class table.
    function automatic void dec(input logic [15:0] ins, output int s1, output int s2, output bit wr);
        int op = int'(ins[15:12]), rd = int'(ins[11:8]);
        s1 = 0; s2 = 0; wr = 0;
        if (op <= 7) begin s1 = int'(ins[7:4]); s2 = int'(ins[3:0]); wr = 1; end
        else if (op == 8) begin s1 = int'(ins[7:4]); wr = 1; end
        else if (op == 9) begin s1 = int'(ins[7:4]); s2 = rd; end
        else if (op == 10 || op == 11) begin s1 = rd; wr = 1; end
        wr = wr && rd != 0;
    endfunction

    function automatic bit wb_hit(int r);
        return wb_en && int'(wb_addr) == r;
    endfunction

    function automatic bit busy(int r);
        return r != 0 && pend[r] && !wb_hit(r);
    endfunction

    function automatic logic [15:0] val(int r);
        return r == 0 ? 16'h0 : wb_hit(r) ? wb_data : regs[r];
    endfunction

    task automatic cycle(output logic rdy_s);
        int s1, s2, op;
        bit wr, hz, rdy, acc;
        @(negedge Clock);
        dec(in_instr, s1, s2, wr);
        op = int'(in_instr[15:12]);
        hz = busy(s1) || busy(s2) || (wr && busy(int'(in_instr[11:8])));
        rdy = !hz && (!mv || out_ready) && !flush;
        rdy_s = in_ready;
        chk("in_ready", in_ready, rdy);
        chk("RAddr1", RAddr1, s1);
        chk("RAddr2", RAddr2, s2);
        acc = in_valid && rdy;
        if (!Reset) begin
            foreach (pend[i]) pend[i] = 0;
            mv = 0; mwen = 0; ma = '0; mb = '0; mpc = '0; mstall = '0; mop = '0; mrd = '0; mimm = '0;
        end else begin
            if (in_valid && hz && mstall != 16'hFFFF) mstall = mstall + 1;
            if (wb_en) pend[wb_addr] = 0;
            if (flush && mv && mwen) pend[mrd] = 0;
            mv = acc || (mv && !out_ready && !flush);
            if (acc) begin
                mop = in_instr[15:12]; mrd = in_instr[11:8]; mwen = wr; mimm = in_instr[3:0]; mpc = in_pc;
                ma = val(s1);
                mb = (op == 10 || op == 11) ? {12'h0, in_instr[7:4]} : val(s2);
                if (wr) pend[in_instr[11:8]] = 1;
            end
        end
        @(posedge Clock);
        #1;
        chk("out_valid", out_valid, mv);
        chk("out_op", out_op, mop);
        chk("out_rd", out_rd, mrd);
        chk("out_wen", out_wen, mwen);
        chk("out_a", out_a, ma);
        chk("out_b", out_b, mb);
        chk("out_imm", out_imm, mimm);
        chk("out_pc", out_pc, mpc);
        chk("stall_cnt", stall_cnt, mstall);
    endtask

    initial begin
        logic r;
        foreach (pend[i]) pend[i] = 0;
        foreach (regs[i]) regs[i] = 16'h1111 * 16'(i);
        regs[0] = 16'hDEAD; regs[2] = 16'h0005; regs[3] = 16'h0007;
        tbl[0]  = '{0,1,16'h0123,1,0,0,0,0, 1,0,1, 16'h0,16'h0,0,0, 0};
        tbl[1]  = '{0,1,16'h0123,1,0,0,0,0, 1,0,1, 16'h0,16'h0,0,0, 0};
        tbl[2]  = '{1,1,16'h0123,1,0,0,0,0, 1,1,1, 16'h5,16'h7,1,1, 0};
        tbl[3]  = '{1,1,16'h1412,1,0,0,0,0, 0,0,1, 16'h5,16'h7,1,1, 1};
        tbl[4]  = '{1,1,16'h1412,1,0,0,0,0, 0,0,1, 16'h5,16'h7,1,1, 2};
        tbl[5]  = '{1,1,16'h1412,1,1,1,16'h00AA,0, 1,1,1, 16'hAA,16'h5,4,1, 2};
        tbl[6]  = '{1,1,16'h0023,1,0,0,0,0, 1,1,1, 16'h5,16'h7,0,0, 2};
        tbl[7]  = '{1,1,16'h0500,1,0,0,0,0, 1,1,1, 16'h0,16'h0,5,1, 2};
        tbl[8]  = '{1,1,16'hC000,0,0,0,0,0, 0,1,1, 16'h0,16'h0,5,1, 2};
        tbl[9]  = '{1,1,16'hC000,0,0,0,0,0, 0,1,1, 16'h0,16'h0,5,1, 2};
        tbl[10] = '{1,1,16'hC000,0,0,0,0,0, 0,1,1, 16'h0,16'h0,5,1, 2};
        tbl[11] = '{1,1,16'hC000,1,0,0,0,0, 1,1,1, 16'h0,16'h0,0,0, 2};
        tbl[12] = '{1,1,16'h8620,1,0,0,0,0, 1,1,1, 16'h5,16'h0,6,1, 2};
        tbl[13] = '{1,1,16'h0766,0,0,0,0,1, 0,0,1, 16'h5,16'h0,6,1, 3};
        tbl[14] = '{1,1,16'h0766,1,0,0,0,0, 1,1,1, 16'h6666,16'h6666,7,1, 3};
        tbl[15] = '{1,0,16'hC000,1,0,0,0,0, 1,0,1, 16'h6666,16'h6666,7,1, 3};
        tbl[16] = '{1,1,16'h0523,1,0,0,0,0, 0,0,1, 16'h6666,16'h6666,7,1, 4};
        tbl[17] = '{1,1,16'h0523,1,1,5,16'h1234,0, 1,1,1, 16'h5,16'h7,5,1, 4};
        tbl[18] = '{1,1,16'h0523,1,0,0,0,0, 0,0,1, 16'h5,16'h7,5,1, 5};
        @(posedge Clock);
        #1;
        for (int i = 0; i < 19; i++) begin
            Reset = tbl[i].rst; in_valid = tbl[i].iv; in_instr = tbl[i].ins; in_pc = 16'h0100 + 16'(i);
            out_ready = tbl[i].ordy; wb_en = tbl[i].wbe; wb_addr = tbl[i].wba; wb_data = tbl[i].wbd;
            flush = tbl[i].fl;
            cycle(r);
            chk($sformatf("v%0d.in_ready", i), r, tbl[i].e_rdy);
            chk($sformatf("v%0d.out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("v%0d.stall_cnt", i), stall_cnt, tbl[i].e_st);
            if (tbl[i].e_chk) begin
                chk($sformatf("v%0d.out_a", i), out_a, tbl[i].e_a);
                chk($sformatf("v%0d.out_b", i), out_b, tbl[i].e_b);
                chk($sformatf("v%0d.out_rd", i), out_rd, tbl[i].e_rd);
                chk($sformatf("v%0d.out_wen", i), out_wen, tbl[i].e_wen);
            end
        end
        // r5 stays pending, so this holds a WAW hazard long enough to saturate
        for (int i = 0; i < 65540; i++) cycle(r);
        chk("stall_sat", stall_cnt, 16'hFFFF);
        Reset = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
        cycle(r);
        chk("reset_stall", stall_cnt, 16'h0);
        chk("reset_valid", out_valid, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            Reset = $urandom_range(63) != 0;
            in_valid = 1'($urandom_range(1));
            in_instr = {4'($urandom_range(15)), 4'($urandom_range(3)), 4'($urandom_range(3)), 4'($urandom_range(3))};
            in_pc = 16'($urandom);
            out_ready = $urandom_range(3) != 0;
            wb_en = 1'($urandom_range(1));
            wb_addr = 4'($urandom_range(3));
            wb_data = 16'($urandom);
            flush = $urandom_range(15) == 0;
            foreach (regs[j]) regs[j] = 16'($urandom);
            cycle(r);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
